// File: rtl/rr_resource_scheduler_pkg.sv
// rr_sched_pkg: shared state type and default sizing for the round-robin scheduler
package rr_sched_pkg;
    typedef enum logic {IDLE, OWN} rr_state_e;
    localparam int RR_N_DEF        = 4;
    localparam int RR_HOLD_MAX_DEF = 8;
endpackage

// File: rtl/rr_resource_scheduler_pick.sv
// rr_pick: combinational rotating priority encoder searching ptr+1, ptr+2, ... with ptr itself last
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int N = RR_N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] vec
);
    // walk the search order backwards so the earliest hit is the one left standing
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
        vec = found ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/rr_resource_scheduler.sv
// rr_resource_scheduler: round-robin owner arbitration for one shared resource.
// Define RR_SCHED_TIMEOUT_EN to build the hold-timeout preemption (hold_cnt, preempt).
// The owner's release strobe is named rel because release is a reserved word.
module rr_resource_scheduler
    import rr_sched_pkg::*;
#(
    parameter int N        = RR_N_DEF,
    parameter int HOLD_MAX = RR_HOLD_MAX_DEF,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         rel,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         busy,
    output logic         preempt
);
    rr_state_e    state;
    logic [W-1:0] ptr;
    logic         idle_found, ho_found, end_c, to_hit;
    logic [W-1:0] idle_idx, ho_idx;
    logic [N-1:0] idle_vec, ho_vec;

    // ptr always names the current owner while in OWN
    assign end_c = rel | ~req[ptr];

    rr_pick #(.N(N)) u_idle (.req(req), .ptr(ptr), .found(idle_found), .idx(idle_idx), .vec(idle_vec));
    rr_pick #(.N(N)) u_ho (.req(req & ~grant), .ptr(ptr), .found(ho_found), .idx(ho_idx), .vec(ho_vec));

`ifdef RR_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] HM1 = CW'(HOLD_MAX - 1);
    logic [CW-1:0] hold_cnt;
    assign to_hit = (hold_cnt == HM1) && ho_found;
    // count owned cycles, restarting on every new or renewed grant and saturating at HOLD_MAX-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hold_cnt <= '0;
        else
            hold_cnt <= (state == IDLE || end_c || to_hit) ? '0 : (hold_cnt == HM1 ? hold_cnt : hold_cnt + 1'b1);
    end
`else
    assign to_hit = 1'b0;
`endif

    // ownership FSM with registered grant, index, busy and preempt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= W'(N - 1);
            busy      <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (state == IDLE) begin
                if (idle_found) begin
                    state     <= OWN;
                    grant     <= idle_vec;
                    grant_idx <= idle_idx;
                    ptr       <= idle_idx;
                    busy      <= 1'b1;
                end
            end else if (end_c || to_hit) begin
                if (ho_found) begin
                    grant     <= ho_vec;
                    grant_idx <= ho_idx;
                    ptr       <= ho_idx;
                    preempt   <= ~end_c;
                end else if (!req[ptr]) begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/rr_resource_scheduler.md
# rr_resource_scheduler

Round-robin scheduler that shares one downstream resource (bus port, memory bank, shared engine) among N requesters with an ownership handshake. A requester raises `req`, receives a registered one-hot `grant`, keeps the resource until it pulses `release` or drops `req`, and is then rotated to lowest priority. An optional hold-timeout preempts owners that keep the resource too long while others wait. It sits between the requester agents and the shared resource's input mux and drives that mux's select.

## Interface
- `N`, 4: number of requesters, at least 2.
- `HOLD_MAX`, 8: maximum owned cycles before preemption (timeout build only), at least 2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester request level.
- `release`  in  1  owner finishes this cycle; ignored when no grant is held.
- `grant`  out  N  registered one-hot grant, or all-zero.
- `grant_idx`  out  $clog2(N)  encoded index of the granted requester; holds its last value while idle.
- `busy`  out  1  high when `grant` is nonzero.
- `preempt`  out  1  one-cycle pulse on a timeout hand-off.

## Operation
- Two states: IDLE (`grant` = 0) and OWN (exactly one `grant` bit set).
- Priority pointer `ptr` points to the last owner. Search order is ptr+1, ptr+2, … wrapping modulo N, so the last owner is searched last.
- IDLE → OWN: at an edge with `req` ≠ 0, grant the first set bit in search order. `ptr` becomes that index.
- OWN end condition: `release` = 1, or `req[owner]` = 0.
  - When the end condition is met and some other `req` bit is set, hand off directly at that edge to the next requester in search order. There is no bubble cycle.
  - When the end condition is met and only the owner still requests, re-grant the same owner.
  - When the end condition is met and `req` = 0, return to IDLE.
- Timeout (macro enabled only):
  - `hold_cnt` resets to 0 on every new grant and increments each OWN cycle, saturating at HOLD_MAX−1.
  - When `hold_cnt` = HOLD_MAX−1 and another requester is pending, hand off at that edge and pulse `preempt`.
  - With no other requester pending, the owner keeps the grant.
- `release` together with timeout at the same edge counts as a normal release. `preempt` stays 0.
- `busy` is 1 exactly when `grant` is nonzero. `grant_idx` matches the encoding of `grant` whenever `busy` = 1.

## Timing
- Reset (asynchronous, `reset` = 0):
  - `grant` = 0, `busy` = 0, `preempt` = 0, `grant_idx` = 0.
  - `ptr` = N−1, so requester 0 has first priority after reset.
  - `hold_cnt` = 0.
  - Reset in the middle of ownership drops the grant immediately, without waiting for a clock edge.
- Latency: `req` sampled nonzero at edge t produces a one-hot `grant` visible after edge t. This gives `req |=> $onehot(grant)` whenever reset is released.
- Hand-off: `release` sampled at edge t moves `grant` to the new owner after edge t. The old and new owners never overlap.
- Worst-case wait with timeout: (N−1)·HOLD_MAX cycles. Without timeout the wait is unbounded.

## Configuration
- `RR_SCHED_TIMEOUT_EN` defined:
  - `hold_cnt` and the preemption logic are built.
  - `preempt` pulses on timeout hand-offs.
- `RR_SCHED_TIMEOUT_EN` not defined:
  - No counter is built and HOLD_MAX is unused.
  - The owner keeps the grant until release or until it drops `req`.
  - `preempt` is tied to 0.

## Structure
- Package `rr_sched_pkg` holds:
  - the `rr_state_e` typedef {IDLE, OWN};
  - default constants `RR_N_DEF` = 4 and `RR_HOLD_MAX_DEF` = 8.
- Sub-module `rr_pick` is a combinational rotating priority encoder.
  - Inputs: `req` and `ptr`.
  - Outputs: `found`, `idx`, and one-hot `vec`.
  - The scheduler instantiates `rr_pick` once for the idle search and once for the hand-off search. The hand-off search masks the owner when it releases; the owner is still searched last.

## Test plan
- Reset release, then `req` = 4'b1010 → `grant` = 4'b0010 after the next edge, `busy` = 1, `grant_idx` = 1.
- Owner 1 pulses `release` with `req` = 4'b1010 held → `grant` = 4'b1000 after the same edge with no bubble. Next release → `grant` = 4'b0010.
- All 4 requesters held high and each owner releases after 2 cycles → grant order 0, 1, 2, 3, 0, … with every `grant` one-hot.
- Single requester 2 releases while keeping `req` high → `grant` stays 4'b0100. When `req` drops to 0 → `grant` = 0 and `busy` = 0 the next cycle.
- Timeout build, HOLD_MAX = 8: owner 0 never releases and `req[3]` = 1 → after 8 owned cycles `grant` = 4'b1000 with a single-cycle `preempt`. Without the macro, `grant` stays 4'b0001 indefinitely.
- Assert `reset` = 0 asynchronously while `grant` = 4'b0100 → `grant` = 0 immediately. After reset release with `req` = 4'b1111 → `grant` = 4'b0001.
